// File: rtl/i2c_register_bank.sv
// Register bank behind the I2C slave: control, status, scratch, interrupt and event-count registers.
// Reads come from a registered address mux; event lines are synchronized and edge-detected.
module i2c_register_bank #(
  parameter logic [31:0] VERSION    = 32'h0001_0000,
  parameter int          EVENT_W    = 16,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         register_address,
  input  logic [31:0]        data_to_register,
  input  logic               data_to_register_wr,
  output logic [31:0]        data_from_register,
  input  logic               data_from_register_rd,
  output logic [31:0]        ctrl_out,
  input  logic [31:0]        status_in,
  input  logic [EVENT_W-1:0] event_in,
  output logic               irq_out
);

  localparam logic [5:0] ADDR_VERSION = 6'h00;
  localparam logic [5:0] ADDR_CONTROL = 6'h01;
  localparam logic [5:0] ADDR_STATUS  = 6'h02;
  localparam logic [5:0] ADDR_PENDING = 6'h03;
  localparam logic [5:0] ADDR_MASK    = 6'h04;
  localparam logic [5:0] ADDR_SCRATCH = 6'h05;
  localparam logic [5:0] ADDR_COUNT   = 6'h06;

  logic [31:0]        ctrl_q, ctrl_d;
  logic [31:0]        scratch_q, scratch_d;
  logic [EVENT_W-1:0] pend_q, pend_d;
  logic [EVENT_W-1:0] mask_q, mask_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic [31:0]        status_s1_q, status_s2_q;
  logic [EVENT_W-1:0] ev_s1_q, ev_s2_q, ev_s3_q;
  logic [EVENT_W-1:0] ev_rise;
  logic [31:0]        pend_ext, mask_ext;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    ev_rise  = ev_s2_q & ~ev_s3_q;
    pend_ext = '0;
    mask_ext = '0;
    pend_ext[EVENT_W-1:0] = pend_q;
    mask_ext[EVENT_W-1:0] = mask_q;

    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    if (data_to_register_wr) begin
      case (register_address)
        ADDR_CONTROL: ctrl_d    = data_to_register;
        ADDR_PENDING: pend_d    = pend_q & ~data_to_register[EVENT_W-1:0];
        ADDR_MASK:    mask_d    = data_to_register[EVENT_W-1:0];
        ADDR_SCRATCH: scratch_d = data_to_register;
        default:      ;
      endcase
    end
    // New edges are ORed in after the W1C so a coincident event is never lost.
    pend_d = pend_d | ev_rise;

    count_d = count_q;
    if (data_from_register_rd && register_address == ADDR_COUNT) count_d = '0;
    if (ev_rise[0]) count_d = sat_inc(count_d);

    irq_d = |(pend_q & mask_q);

    case (register_address)
      ADDR_VERSION: rdata_d = VERSION;
      ADDR_CONTROL: rdata_d = ctrl_q;
      ADDR_STATUS:  rdata_d = status_s2_q;
      ADDR_PENDING: rdata_d = pend_ext;
      ADDR_MASK:    rdata_d = mask_ext;
      ADDR_SCRATCH: rdata_d = scratch_q;
      ADDR_COUNT:   rdata_d = count_q;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= CTRL_RESET;
      scratch_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  // Two-flop synchronizers; the third event flop only feeds edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_s1_q <= '0;
      status_s2_q <= '0;
      ev_s1_q     <= '0;
      ev_s2_q     <= '0;
      ev_s3_q     <= '0;
    end else begin
      status_s1_q <= status_in;
      status_s2_q <= status_s1_q;
      ev_s1_q     <= event_in;
      ev_s2_q     <= ev_s1_q;
      ev_s3_q     <= ev_s2_q;
    end
  end

  assign data_from_register = rdata_q;
  assign ctrl_out           = ctrl_q;
  assign irq_out            = irq_q;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Self-checking bench for i2c_register_bank: directed test-plan steps followed by
// randomized traffic, all compared every cycle against a register-map reference model.
module tb_i2c_register_bank;

  localparam logic [31:0] VERSION    = 32'h0001_0000;
  localparam int          EW         = 16;
  localparam logic [31:0] CTRL_RESET = 32'h0000_0000;
  localparam logic [31:0] EV_MASK    = 32'h0000_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    register_address;
  logic [31:0]   data_to_register;
  logic          data_to_register_wr;
  logic [31:0]   data_from_register;
  logic          data_from_register_rd;
  logic [31:0]   ctrl_out;
  logic [31:0]   status_in;
  logic [EW-1:0] event_in;
  logic          irq_out;

  int checks   = 0;
  int failures = 0;

  i2c_register_bank #(
    .VERSION(VERSION), .EVENT_W(EW), .CTRL_RESET(CTRL_RESET)
  ) dut (
    .clk(clk), .rst(rst),
    .register_address(register_address),
    .data_to_register(data_to_register),
    .data_to_register_wr(data_to_register_wr),
    .data_from_register(data_from_register),
    .data_from_register_rd(data_from_register_rd),
    .ctrl_out(ctrl_out),
    .status_in(status_in),
    .event_in(event_in),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus the input samples seen at recent edges.
  logic [31:0] m_ctrl, m_scratch, m_pend, m_mask, m_cnt, m_rdata;
  logic        m_irq;
  logic [31:0] st_hist[$];
  logic [31:0] ev_hist[$];

  task automatic model_reset();
    m_ctrl = CTRL_RESET; m_scratch = 0; m_pend = 0; m_mask = 0; m_cnt = 0;
    m_rdata = 0; m_irq = 1'b0;
    st_hist = '{32'h0, 32'h0, 32'h0};
    ev_hist = '{32'h0, 32'h0, 32'h0};
  endtask

  // An input change is seen as an event two edges after it is first sampled.
  task automatic model_edge();
    logic [31:0] rise, nrd;
    rise = ev_hist[1] & ~ev_hist[2];
    case (register_address)
      6'h00:   nrd = VERSION;
      6'h01:   nrd = m_ctrl;
      6'h02:   nrd = st_hist[1];
      6'h03:   nrd = m_pend;
      6'h04:   nrd = m_mask;
      6'h05:   nrd = m_scratch;
      6'h06:   nrd = m_cnt;
      default: nrd = 0;
    endcase
    m_irq = (m_pend & m_mask) != 0;
    if (data_to_register_wr) begin
      if (register_address == 6'h01) m_ctrl = data_to_register;
      if (register_address == 6'h03) m_pend = m_pend & ~data_to_register;
      if (register_address == 6'h04) m_mask = data_to_register & EV_MASK;
      if (register_address == 6'h05) m_scratch = data_to_register;
    end
    m_pend = m_pend | rise;
    if (data_from_register_rd && register_address == 6'h06) m_cnt = 0;
    if (rise[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_rdata = nrd;
    st_hist.push_front(status_in);
    void'(st_hist.pop_back());
    ev_hist.push_front(32'(event_in));
    void'(ev_hist.pop_back());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check("model_rdata", data_from_register, m_rdata);
    check("model_ctrl", ctrl_out, m_ctrl);
    check("model_irq", 32'(irq_out), 32'(m_irq));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    register_address = a; data_to_register = d; data_to_register_wr = 1'b1;
    step();
    data_to_register_wr = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] v);
    register_address = a;
    step();
    v = data_from_register;
    data_from_register_rd = 1'b1;
    step();
    data_from_register_rd = 1'b0;
  endtask

  task automatic pulse_events(input logic [EW-1:0] bits);
    event_in = bits;
    step();
    event_in = '0;
    step();
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b0; register_address = 0; data_to_register = 0; data_to_register_wr = 0;
    data_from_register_rd = 0; status_in = 0; event_in = 0;
    model_reset();
    steps(2);
    check("reset_ctrl", ctrl_out, CTRL_RESET);
    check("reset_irq", 32'(irq_out), 32'h0);
    check("reset_rdata", data_from_register, 32'h0);
    #2 rst = 1'b1;

    do_read(6'h00, v); check("read_version", v, 32'h0001_0000);
    do_read(6'h01, v); check("read_ctrl_reset", v, CTRL_RESET);

    do_write(6'h01, 32'hA5A5_1234);
    check("ctrl_out_after_write", ctrl_out, 32'hA5A5_1234);
    do_read(6'h01, v); check("ctrl_readback", v, 32'hA5A5_1234);
    do_write(6'h00, 32'hFFFF_FFFF);
    do_read(6'h00, v); check("version_ro", v, 32'h0001_0000);
    do_write(6'h05, 32'hDEAD_BEEF);
    do_read(6'h05, v); check("scratch_readback", v, 32'hDEAD_BEEF);
    do_write(6'h04, 32'hFFFF_FFFF);
    do_read(6'h04, v); check("mask_width", v, 32'h0000_FFFF);
    do_write(6'h04, 32'h0);
    do_write(6'h3F, 32'h1234_5678);
    do_read(6'h3F, v); check("unmapped_read", v, 32'h0);

    // Single event on line 3 with the mask closed.
    register_address = 6'h03;
    event_in = 16'h0008;
    steps(3);
    event_in = '0;
    step();
    check("pending_after_3", data_from_register, 32'h0000_0008);
    check("irq_masked", 32'(irq_out), 32'h0);
    do_write(6'h04, 32'h8);
    step();
    check("irq_unmasked", 32'(irq_out), 32'h1);
    do_write(6'h03, 32'h8);
    step();
    check("irq_after_w1c", 32'(irq_out), 32'h0);
    do_read(6'h03, v); check("pending_cleared", v, 32'h0);

    // A held level counts once.
    event_in = 16'h0002;
    steps(8);
    event_in = '0;
    steps(3);
    do_read(6'h03, v); check("held_level_pending", v, 32'h0000_0002);
    do_write(6'h03, 32'h2);

    // Set wins over a coincident W1C.
    pulse_events(16'h0020);
    steps(4);
    event_in = 16'h0020;
    steps(2);
    do_write(6'h03, 32'h20);
    event_in = '0;
    steps(3);
    do_read(6'h03, v); check("set_beats_clear", v, 32'h0000_0020);
    do_write(6'h03, 32'h20);

    // Event counter, clear-on-read, coincident edge.
    do_read(6'h06, v);
    for (int i = 0; i < 5; i++) pulse_events(16'h0001);
    steps(4);
    do_read(6'h06, v); check("count_five", v, 32'd5);
    do_read(6'h06, v); check("count_cleared", v, 32'd0);
    event_in = 16'h0001;
    step();
    do_read(6'h06, v); check("count_coincident_ret", v, 32'd0);
    event_in = '0;
    steps(3);
    do_read(6'h06, v); check("count_coincident", v, 32'd1);

    // Status path.
    status_in = 32'hC0FF_EE11;
    steps(3);
    do_read(6'h02, v); check("status_sync", v, 32'hC0FF_EE11);

    // Asynchronous reset mid-operation.
    do_write(6'h01, 32'h1);
    do_write(6'h04, 32'hF);
    do_write(6'h03, 32'hFFFF);
    do_read(6'h06, v);
    pulse_events(16'h000F);
    for (int i = 0; i < 6; i++) pulse_events(16'h0001);
    steps(4);
    register_address = 6'h06;
    step();
    check("pre_reset_count", data_from_register, 32'd7);
    check("pre_reset_irq", 32'(irq_out), 32'h1);
    register_address = 6'h01;
    event_in = 16'h0001;
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_ctrl", ctrl_out, CTRL_RESET);
    check("async_irq", 32'(irq_out), 32'h0);
    check("async_rdata", data_from_register, 32'h0);
    steps(2);
    #2 rst = 1'b1;
    event_in = '0;
    steps(4);
    do_read(6'h03, v); check("post_reset_pending", v, 32'h0);
    do_read(6'h06, v); check("post_reset_count", v, 32'h0);
    do_read(6'h04, v); check("post_reset_mask", v, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      register_address      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      data_to_register      = $urandom;
      data_to_register_wr   = ($urandom_range(0, 3) == 0);
      data_from_register_rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) status_in = $urandom;
      event_in = event_in ^ EW'($urandom & $urandom & $urandom);
      step();
    end
    data_to_register_wr = 0; data_from_register_rd = 0;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_register_bank.md
Name: i2c_register_bank

Overview:
Register file directly downstream of the FPGA I2C slave interface. It consumes the slave's register address, write data and write strobe, and it supplies 32-bit read data on the slave's read strobe. It holds the control, scratch, interrupt and event-counter registers that the MCU accesses over I2C, and it drives the control outputs and the MCU interrupt line.

Parameters:
VERSION, 32'h0001_0000, constant value returned at address 0x00
EVENT_W, 16, number of event inputs, 1..32; interrupt pending and mask registers are EVENT_W bits, zero-extended on read
CTRL_RESET, 32'h0000_0000, reset value of the CONTROL register and ctrl_out

Ports:
clk  input  1  system clock, same clock as the I2C slave
rst  input  1  asynchronous, active-low reset
register_address  input  6  register address from the I2C slave, stable between transactions
data_to_register  input  32  write data from the I2C slave
data_to_register_wr  input  1  single-cycle write strobe
data_from_register  output  32  read data to the I2C slave
data_from_register_rd  input  1  single-cycle read strobe; the slave captures data_from_register in this cycle
ctrl_out  output  32  CONTROL register contents
status_in  input  32  asynchronous status levels
event_in  input  EVENT_W  asynchronous event lines; rising edges are counted as events
irq_out  output  1  interrupt to the MCU, active high

Behaviour:
- Reset (rst low, asynchronous): CONTROL=CTRL_RESET, SCRATCH=0, IRQ_PENDING=0, IRQ_MASK=0, EVENT_COUNT=0, data_from_register=0, irq_out=0, all synchronizer flops=0.
- Register map (address: name, access):
  - 0x00 VERSION, RO.
  - 0x01 CONTROL, RW.
  - 0x02 STATUS, RO, synchronized status_in.
  - 0x03 IRQ_PENDING, W1C.
  - 0x04 IRQ_MASK, RW, low EVENT_W bits.
  - 0x05 SCRATCH, RW.
  - 0x06 EVENT_COUNT, RO, clear-on-read.
  - All other addresses read 0; writes to them are ignored.
- Writes: take effect on the clk edge where data_to_register_wr=1, using register_address and data_to_register from that cycle. Writes to RO addresses are ignored. IRQ_MASK keeps bits [EVENT_W-1:0] only.
- Read path: data_from_register is a registered mux of register_address, reloaded every clk. Latency is 1 cycle from an address change. The value is therefore stable and valid whenever data_from_register_rd is high, because the address settles many cycles before a read strobe.
- Synchronization: status_in and event_in pass through 2-flop synchronizers. A third flop on event_in provides edge detection. An event edge is ev_rise = sync2 & ~sync3.
- IRQ_PENDING: bit i is set on ev_rise[i]. A write to 0x03 clears every bit written as 1. If set and clear hit the same bit in the same cycle, set wins (the bit stays 1).
  - Pending becomes visible 3 cycles after an event_in rising edge.
  - An event_in level held high generates exactly one edge.
- irq_out: registered |(IRQ_PENDING & IRQ_MASK), 1 cycle after the pending or mask update.
- EVENT_COUNT: 32-bit counter of ev_rise[0]. Saturates at 32'hFFFF_FFFF, with no wrap.
  - When data_from_register_rd=1 and register_address=0x06, the counter clears.
  - The read returns the pre-clear value, already held in data_from_register.
  - If an ev_rise[0] occurs in the same cycle as the clearing read, the counter becomes 1.
- Simultaneous write and read strobes: not produced by the slave. If both occur, the write is performed and the read side effect is also performed.
- Reset mid-transaction: all state returns immediately to the reset values. Pending events inside the synchronizers are lost.

Test Plan:
- Reset, then read 0x00 and 0x01 -> 32'h0001_0000 and CTRL_RESET. irq_out=0. ctrl_out=CTRL_RESET.
- Write 0x01=32'hA5A5_1234, then read back -> ctrl_out=32'hA5A5_1234 one cycle after the strobe. Readback matches. Write 0x00=32'hFFFF_FFFF -> VERSION unchanged.
- Pulse event_in[3], with mask=0 -> IRQ_PENDING=32'h0000_0008 after 3 cycles, irq_out=0. Write mask=32'h8 -> irq_out=1 one cycle later. Write 0x03=32'h8 -> pending=0, irq_out=0.
- Assert event_in[5] rise on the exact cycle that a W1C write of 32'h20 lands -> pending bit 5 remains 1.
- Apply 5 rising edges on event_in[0], then read 0x06 -> returns 5. A second read returns 0. An edge coincident with the clearing read leaves the count at 1.
- Drop rst low mid-operation with CONTROL=32'h1, pending=32'hF, count=7 -> all outputs return to reset values asynchronously (before the next clk edge).
